// File: rtl/stmt_while_sched.sv
// Round-robin shared accumulate engine: one granted job iterates
// sum += data + idx, idx++ for lim cycles, then returns the result on a valid/ready port.
module stmt_while_sched #(
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4,
  parameter int DEF_LIMIT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [IDX_W-1:0]  req0_start_idx,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [IDX_W-1:0]  req1_start_idx,
  input  logic              cfg_limit_valid,
  input  logic [IDX_W-1:0]  cfg_limit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic [IDX_W-1:0]  res_index,
  output logic              res_src,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitrate requesters, accept one job
  // RUN   | one accumulate iteration per clock
  // DONE  | result presented, waiting for res_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] DEF_LIM = IDX_W'(DEF_LIMIT);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] cur_sum;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  lim;
  logic [IDX_W-1:0]  cnt;
  logic              src;
  logic              last_grant;
  logic              grant0, grant1, accept;
  logic [IDX_W-1:0]  lim_in;

  // On contention the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
  assign accept = (state == IDLE) && (grant0 || grant1);
  assign lim_in = cfg_limit_valid ? cfg_limit : DEF_LIM;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (lim_in == '0) ? DONE : RUN;
      RUN:  if (cnt == lim - IDX_W'(1)) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    res_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r     <= '0;
      cur_sum    <= '0;
      cur_idx    <= '0;
      lim        <= '0;
      cnt        <= '0;
      src        <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      data_r     <= grant1 ? req1_data : req0_data;
      cur_idx    <= grant1 ? req1_start_idx : req0_start_idx;
      cur_sum    <= '0;
      lim        <= lim_in;
      cnt        <= '0;
      src        <= grant1;
      last_grant <= grant1;
    end else if (state == RUN) begin
      cur_sum <= cur_sum + data_r + DATA_W'(cur_idx);
      cur_idx <= cur_idx + IDX_W'(1);
      cnt     <= cnt + IDX_W'(1);
    end
  end

  // Result registers double as the working registers; they are frozen in DONE.
  assign res_sum   = cur_sum;
  assign res_index = cur_idx;
  assign res_src   = src;

endmodule

// File: tb/tb_stmt_while_sched.sv
// Scoreboarded bench for stmt_while_sched: a cycle model predicts grants and
// result timing, a monitor pops expected results on each result handshake.
module tb_stmt_while_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [3:0] req0_start_idx, req1_start_idx;
  logic       cfg_limit_valid;
  logic [3:0] cfg_limit;
  logic       res_valid, res_ready;
  logic [7:0] res_sum;
  logic [3:0] res_index;
  logic       res_src;
  logic       busy;

  stmt_while_sched #(.DATA_W(8), .IDX_W(4), .DEF_LIMIT(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_start_idx(req0_start_idx),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_start_idx(req1_start_idx),
    .cfg_limit_valid(cfg_limit_valid), .cfg_limit(cfg_limit),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_index(res_index), .res_src(res_src),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int sum; int idx; int src; } res_t;
  res_t q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit m_busy = 0;
  bit m_last = 1;
  int done_at = 0;
  bit acc0 = 0, acc1 = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: the while loop written out plainly.
  function automatic void calc(int d, int s, int l, output int sum, output int idx);
    sum = 0;
    idx = s;
    for (int i = 0; i < l; i++) begin
      sum = (sum + d + idx) % 256;
      idx = (idx + 1) % 16;
    end
  endfunction

  task automatic model_eval();
    bit g0, g1;
    int l, s, ix;
    res_t r;
    cyc++;
    acc0 = 0;
    acc1 = 0;
    if (!rst_n) begin
      q.delete();
      m_busy = 0;
      m_last = 1;
      return;
    end
    if (!m_busy) begin
      g0 = req0_valid && (!req1_valid || m_last);
      g1 = req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", int'(req0_ready), int'(g0));
      chk("req1_ready", int'(req1_ready), int'(g1));
      chk("res_valid_idle", int'(res_valid), 0);
      chk("busy_idle", int'(busy), 0);
      if (g0 || g1) begin
        l = cfg_limit_valid ? int'(cfg_limit) : 5;
        if (g1) calc(int'(req1_data), int'(req1_start_idx), l, s, ix);
        else    calc(int'(req0_data), int'(req0_start_idx), l, s, ix);
        r.sum = s; r.idx = ix; r.src = int'(g1);
        q.push_back(r);
        m_busy = 1;
        m_last = g1;
        done_at = cyc + 1 + l;
        acc0 = g0;
        acc1 = g1;
      end
    end else begin
      chk("req0_ready_busy", int'(req0_ready), 0);
      chk("req1_ready_busy", int'(req1_ready), 0);
      chk("busy_run", int'(busy), 1);
      chk("res_valid_timing", int'(res_valid), int'(cyc >= done_at));
      if (cyc >= done_at && res_ready) m_busy = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each result handshake, checks hold stability.
  initial begin
    res_t e;
    bit have_prev = 0;
    int p_sum = 0, p_idx = 0, p_src = 0;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (have_prev) begin
          chk("hold_sum", int'(res_sum), p_sum);
          chk("hold_index", int'(res_index), p_idx);
          chk("hold_src", int'(res_src), p_src);
        end
        if (res_ready) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q.pop_front();
            chk("res_sum", int'(res_sum), e.sum);
            chk("res_index", int'(res_index), e.idx);
            chk("res_src", int'(res_src), e.src);
          end
          have_prev = 0;
        end else begin
          p_sum = int'(res_sum); p_idx = int'(res_index); p_src = int'(res_src);
          have_prev = 1;
        end
      end else have_prev = 0;
    end
  end

  task automatic wait_idle(string name);
    int n = 0;
    while (m_busy && n < 60) begin step(); n++; end
    if (m_busy) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic run_job(int r, int d, int s, int lv, int l);
    int n = 0;
    cfg_limit_valid = lv[0];
    cfg_limit = 4'(l);
    res_ready = 1;
    if (r == 0) begin req0_valid = 1; req0_data = 8'(d); req0_start_idx = 4'(s); end
    else        begin req1_valid = 1; req1_data = 8'(d); req1_start_idx = 4'(s); end
    do begin step(); n++; end while (!(acc0 || acc1) && n < 20);
    if (!(acc0 || acc1)) chk("accept_timeout", 0, 1);
    req0_valid = 0;
    req1_valid = 0;
    wait_idle("job");
  endtask

  initial begin
    int n;
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_data = 0; req1_data = 0; req0_start_idx = 0; req1_start_idx = 0;
    cfg_limit_valid = 0; cfg_limit = 0; res_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_sum", int'(res_sum), 0);
    chk("rst_res_index", int'(res_index), 0);
    chk("rst_res_src", int'(res_src), 0);
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // Arbitration: both requesters always valid from reset.
    req0_valid = 1; req1_valid = 1;
    req0_data = 8'h11; req0_start_idx = 4'd1;
    req1_data = 8'h22; req1_start_idx = 4'd3;
    cfg_limit_valid = 1; cfg_limit = 4'd2;
    n = 0;
    for (int k = 0; k < 4 && n < 200; ) begin
      step(); n++;
      if (acc0) begin chk("arb_order", 0, k % 2); k++; req0_data = 8'($urandom); end
      if (acc1) begin chk("arb_order", 1, k % 2); k++; req1_data = 8'($urandom); end
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle("arb");

    // Reset to restore last_grant=1 so req0 is preferred again.
    rst_n = 0; step(); rst_n = 1; step();

    run_job(0, 3, 2, 0, 0);        // default limit: sum 35, idx 7
    run_job(1, 255, 14, 1, 5);     // wrap: sum 27, idx 3
    run_job(0, 77, 9, 1, 0);       // zero limit: sum 0, idx 9

    // Backpressure with req1 waiting.
    cfg_limit_valid = 1; cfg_limit = 4'd3;
    req0_valid = 1; req0_data = 8'd5; req0_start_idx = 4'd4;
    res_ready = 0;
    step();
    req0_valid = 0;
    req1_valid = 1; req1_data = 8'd9; req1_start_idx = 4'd0;
    n = 0;
    while (cyc < done_at && n < 20) begin step(); n++; end
    repeat (4) step();
    res_ready = 1;
    step();
    step();
    chk("bp_req1_accept", int'(acc1), 1);
    req1_valid = 0;
    wait_idle("bp");

    // Reset during RUN iteration 2.
    req1_valid = 1; req1_data = 8'd40; req1_start_idx = 4'd6;
    cfg_limit_valid = 0;
    step();
    req1_valid = 0;
    step(); step();
    rst_n = 0;
    step();
    rst_n = 1;
    req0_valid = 1; req1_valid = 1;
    step();
    chk("post_rst_grant0", int'(acc0), 1);
    req0_valid = 0; req1_valid = 0;
    wait_idle("post_rst");

    // Randomized traffic with random backpressure and cfg churn.
    for (int i = 0; i < 400; i++) begin
      cfg_limit_valid = 1'($urandom_range(0, 3) != 0);
      cfg_limit = 4'($urandom_range(0, 7));
      res_ready = 1'($urandom_range(0, 2) != 0);
      step();
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1; req0_data = 8'($urandom); req0_start_idx = 4'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1; req1_data = 8'($urandom); req1_start_idx = 4'($urandom);
      end
    end
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    wait_idle("drain");
    step();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stmt_while_sched.md
Name: stmt_while_sched

Overview:
- Shared iterative accumulate engine with a two-requester round-robin arbiter.
- Each job runs `cur_sum += data + cur_idx; cur_idx++` for `limit` iterations, one iteration per clock.
- The result returns on a valid/ready result port, tagged with the source requester.
- Sits between two statement-level producers and a single consumer. It replaces the combinational unrolled while-loop with a sequenced, resource-shared version.

Parameters:
- DATA_W, 8, width of data operand and sum.
- IDX_W, 4, width of index and iteration count.
- DEF_LIMIT, 5, iteration count used when cfg_limit_valid is low.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_data  in  DATA_W  requester 0 data operand.
- req0_start_idx  in  IDX_W  requester 0 start index.
- req1_valid, req1_ready, req1_data, req1_start_idx: same as requester 0, for requester 1.
- cfg_limit_valid  in  1  use cfg_limit instead of DEF_LIMIT.
- cfg_limit  in  IDX_W  runtime iteration count, sampled at accept.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  DATA_W  accumulated sum.
- res_index  out  IDX_W  final index.
- res_src  out  1  requester id of the result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; res_valid, res_sum, res_index, res_src, busy, req0_ready, req1_ready all 0.
  - Internal counters cleared; last_grant=1, so requester 0 wins first.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to the requester other than last_grant.
  - Granted reqN_ready is driven combinationally high in that cycle only; both readys are 0 outside IDLE.
- IDLE, accept (at the clock edge of the grant):
  - Latch data and start_idx into cur_idx.
  - Latch lim = cfg_limit_valid ? cfg_limit : DEF_LIMIT.
  - cur_sum=0, cnt=0; src and last_grant = granted id.
  - lim==0: next state DONE (sum 0, index=start_idx). Otherwise: next state RUN.
- RUN, each cycle:
  - cur_sum <= cur_sum + data + zero-extended cur_idx, truncated mod 2^DATA_W.
  - cur_idx <= cur_idx+1, mod 2^IDX_W (wraps 15->0).
  - cnt <= cnt+1.
  - When cnt == lim-1, this is the last iteration; next state DONE.
- DONE:
  - res_valid=1; res_sum, res_index, res_src are registered and stable while res_valid is high.
  - res_valid && res_ready: IDLE next cycle and res_valid drops.
  - res_ready low: hold indefinitely (backpressure); no new job accepted.
- Latency: accept at cycle T -> res_valid first high at T+1+lim (T+1 when lim==0).
- Throughput: a new accept can occur at the earliest in the cycle after the result handshake.
- Requester inputs are ignored outside IDLE; requesters must hold valid and payload until ready.
- cfg_limit changes after accept do not affect the running job.
- Reset mid-RUN or mid-DONE: job dropped, no result emitted, all outputs return to reset values next cycle.
- busy = (state != IDLE).

Test Plan:
1. Single job, timing and sum:
   - Stimulus: req0 data=3, start_idx=2, default limit 5.
   - Response: req0_ready high 1 cycle; res_valid 6 cycles after accept; res_sum=35, res_index=7, res_src=0.
2. Wrap-around:
   - Stimulus: req1 data=0xFF, start_idx=14, limit 5.
   - Response: res_sum=27 (1307 mod 256), res_index=3, res_src=1.
3. Arbitration:
   - Stimulus: both requesters continuously valid from reset with distinct payloads.
   - Response: results ordered src 0,1,0,1; no requester served twice in a row.
4. Zero limit:
   - Stimulus: cfg_limit_valid=1, cfg_limit=0, req0 start_idx=9.
   - Response: res_valid the cycle after accept, res_sum=0, res_index=9.
5. Backpressure:
   - Stimulus: hold res_ready low 4 cycles in DONE while req1 is valid.
   - Response: res_* held stable, req1_ready=0; after handshake, req1 is accepted in the next IDLE cycle.
6. Reset mid-job:
   - Stimulus: assert rst_n=0 at RUN iteration 2.
   - Response: next cycle res_valid=0, busy=0, no result emitted; first post-reset grant goes to req0.
